// File: rtl/cpu_run_monitor.sv
// Run controller and monitor for the RISC-V CPU: sequences CPU reset, counts cycles and
// retired instructions, judges pass/fail at the halt instruction, and keeps a register-write trace.
module cpu_run_monitor #(
    parameter int unsigned      XLEN           = 32,
    parameter int unsigned      RESET_CYCLES   = 2,
    parameter int unsigned      TIMEOUT_CYCLES = 1000,
    parameter logic [31:0]      HALT_INST      = 32'h00000073,
    parameter logic [4:0]       RESULT_REG     = 5'd10,
    parameter logic [XLEN-1:0]  PASS_VALUE     = '0,
    parameter int unsigned      TRACE_DEPTH    = 16,
    localparam int unsigned     TW             = $clog2(TRACE_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   pc,
    input  logic [31:0]       inst,
    input  logic              inst_valid,
    input  logic              reg_write_en,
    input  logic [4:0]        reg_write_addr,
    input  logic [XLEN-1:0]   reg_write_value,
    output logic              cpu_reset,
    output logic              running,
    output logic              done,
    output logic              pass,
    output logic              timed_out,
    output logic [31:0]       cycle_count,
    output logic [31:0]       retired_count,
    output logic [XLEN-1:0]   halt_pc,
    output logic [TW:0]       trace_count,
    input  logic [TW-1:0]     trace_rd_idx,
    output logic [5+XLEN-1:0] trace_rd_data
);

    typedef enum logic [1:0] {
        S_HOLD,
        S_RUN,
        S_HALTED,
        S_TIMEOUT
    } state_e;

    localparam int unsigned HW             = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST    = HW'(RESET_CYCLES - 1);
    localparam logic [31:0]   RUN_LAST     = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [TW:0]   TRACE_FULL   = (TW + 1)'(TRACE_DEPTH);

    state_e            state_q;
    logic [HW-1:0]     hold_cnt_q;
    logic              cpu_reset_q;
    logic              done_q;
    logic              pass_q;
    logic              timed_out_q;
    logic [31:0]       cycle_count_q;
    logic [31:0]       retired_count_q;
    logic [XLEN-1:0]   halt_pc_q;
    logic [XLEN-1:0]   shadow_q;
    logic [XLEN-1:0]   shadow_d;
    logic [TW-1:0]     wptr_q;
    logic [TW:0]       trace_count_q;
    logic [5+XLEN-1:0] trace_rd_data_q;
    logic [TW-1:0]     rd_addr;
    logic              in_run;
    logic              halt_hit;
    logic              trace_we;

    logic [5+XLEN-1:0] trace_mem [TRACE_DEPTH];

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        shadow_d = shadow_q;
        in_run   = (state_q == S_RUN);
        halt_hit = in_run && inst_valid && (inst == HALT_INST);
        trace_we = in_run && reg_write_en && (reg_write_addr != 5'd0);
        rd_addr  = wptr_q - TW'(1) - trace_rd_idx;
        // A result write in the halt cycle must be seen by the pass decision.
        if (trace_we && (reg_write_addr == RESULT_REG)) begin
            shadow_d = reg_write_value;
        end
    end

    // NOTE: the trace RAM has no reset so it maps onto block/distributed RAM; trace_count guards validity.
    always_ff @(posedge clk) begin
        if (trace_we) begin
            trace_mem[wptr_q] <= {reg_write_addr, reg_write_value};
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_HOLD;
            hold_cnt_q      <= '0;
            cpu_reset_q     <= 1'b1;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            timed_out_q     <= 1'b0;
            cycle_count_q   <= '0;
            retired_count_q <= '0;
            halt_pc_q       <= '0;
            shadow_q        <= '0;
            wptr_q          <= '0;
            trace_count_q   <= '0;
            trace_rd_data_q <= '0;
        end else begin
            trace_rd_data_q <= trace_mem[rd_addr];
            case (state_q)
                S_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_q     <= S_RUN;
                        cpu_reset_q <= 1'b0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HW'(1);
                    end
                end
                S_RUN: begin
                    if (cycle_count_q != '1) begin
                        cycle_count_q <= cycle_count_q + 32'd1;
                    end
                    if (inst_valid && (retired_count_q != '1)) begin
                        retired_count_q <= retired_count_q + 32'd1;
                    end
                    shadow_q <= shadow_d;
                    if (trace_we) begin
                        wptr_q <= wptr_q + TW'(1);
                        if (trace_count_q != TRACE_FULL) begin
                            trace_count_q <= trace_count_q + (TW + 1)'(1);
                        end
                    end
                    // Halt takes priority over the watchdog in the same cycle.
                    if (halt_hit) begin
                        state_q     <= S_HALTED;
                        done_q      <= 1'b1;
                        pass_q      <= (shadow_d == PASS_VALUE);
                        halt_pc_q   <= pc;
                        cpu_reset_q <= 1'b1;
                    end else if (cycle_count_q == RUN_LAST) begin
                        state_q     <= S_TIMEOUT;
                        done_q      <= 1'b1;
                        pass_q      <= 1'b0;
                        timed_out_q <= 1'b1;
                        cpu_reset_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign cpu_reset     = cpu_reset_q;
    assign running       = (state_q == S_RUN);
    assign done          = done_q;
    assign pass          = pass_q;
    assign timed_out     = timed_out_q;
    assign cycle_count   = cycle_count_q;
    assign retired_count = retired_count_q;
    assign halt_pc       = halt_pc_q;
    assign trace_count   = trace_count_q;
    assign trace_rd_data = trace_rd_data_q;

endmodule
